// File: rtl/gppcu_rr_arbiter.sv
// Round-robin arbiter sharing one GPPCU datapath resource among 2^EBW lanes.
// Grants are held while the owner requests, with optional timeout preemption.
module gppcu_rr_arbiter #(
    parameter int unsigned EBW      = 4,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNTW     = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [(1<<EBW)-1:0]   REQ,
    input  logic                  LOCK,
    output logic [(1<<EBW)-1:0]   GNT,
    output logic [EBW-1:0]        GNT_IDX,
    output logic                  GNT_VALID,
    output logic                  PREEMPT
);

    localparam int unsigned       N        = 1 << EBW;
    localparam logic [N-1:0]      ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]   HOLD_LIM = CNTW'(HOLD_MAX);
    localparam bit                HOLD_EN  = (HOLD_MAX != 0);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [EBW-1:0]    ptr_q, ptr_d;
    logic [EBW-1:0]    idx_q, idx_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              preempt_q, preempt_d;

    logic [EBW-1:0]    search_start;
    logic [N-1:0]      search_req;
    logic [N-1:0]      rot_req;
    logic [EBW-1:0]    win_off;
    logic [EBW-1:0]    win_idx;
    logic              win_found;
    logic              owner_req;
    logic              timeout;

    // While owned, the owner is excluded and the search begins just after it,
    // which covers both release hand-over and timeout revocation.
    always_comb begin
        if (state_q == ST_IDLE) begin
            search_start = ptr_q;
            search_req   = REQ;
        end else begin
            search_start = idx_q + 1'b1;
            search_req   = REQ & ~gnt_q;
        end
    end

    // rot_req[k] is the request seen k places after the search start.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot_req[gi] = search_req[search_start + EBW'(gi)];
        end
    endgenerate

    always_comb begin
        win_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_off = EBW'(k);
            end
        end
    end

    assign win_found = |rot_req;
    assign win_idx   = search_start + win_off;
    assign owner_req = REQ[idx_q];
    assign timeout   = HOLD_EN && (cnt_q >= HOLD_LIM) && !LOCK && win_found;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_OWNED;
                    idx_d   = win_idx;
                    gnt_d   = ONE_HOT0 << win_idx;
                    cnt_d   = CNTW'(1);
                end
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    ptr_d = idx_q + 1'b1;
                    if (win_found) begin
                        idx_d = win_idx;
                        gnt_d = ONE_HOT0 << win_idx;
                        cnt_d = CNTW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (timeout) begin
                    ptr_d     = idx_q + 1'b1;
                    idx_d     = win_idx;
                    gnt_d     = ONE_HOT0 << win_idx;
                    cnt_d     = CNTW'(1);
                    preempt_d = 1'b1;
                end else if (cnt_q != {CNTW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase

        valid_d = |gnt_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign GNT       = gnt_q;
    assign GNT_IDX   = idx_q;
    assign GNT_VALID = valid_q;
    assign PREEMPT   = preempt_q;

endmodule

// File: tb/tb_gppcu_rr_arbiter.sv
// Self-checking bench for gppcu_rr_arbiter: fixed vector tables, corner
// sequences and randomized traffic against a behavioural model.
module tb_gppcu_rr_arbiter;

    localparam int EBW  = 2;
    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int CNTW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic           lock;
    logic [N-1:0]   gnt;
    logic [EBW-1:0] gnt_idx;
    logic           gnt_valid;
    logic           preempt;

    always #5 clk = ~clk;

    gppcu_rr_arbiter #(
        .EBW      (EBW),
        .HOLD_MAX (HOLD),
        .CNTW     (CNTW)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ       (req),
        .LOCK      (lock),
        .GNT       (gnt),
        .GNT_IDX   (gnt_idx),
        .GNT_VALID (gnt_valid),
        .PREEMPT   (preempt)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: owner as an integer (-1 = idle), unbounded hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_pre   = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] q, input bit lk);
        int w;
        logic [N-1:0] others;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_pre = 1'b0;
            return;
        end
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = pick(q, m_ptr);
            if (w >= 0) begin m_owner = w; m_cnt = 1; end
        end else begin
            others = q;
            others[m_owner] = 1'b0;
            w = pick(others, (m_owner + 1) % N);
            if (!q[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = w;
                m_cnt   = (w >= 0) ? 1 : 0;
            end else if (HOLD != 0 && m_cnt >= HOLD && !lk && w >= 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = w;
                m_cnt   = 1;
                m_pre   = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic drive(input bit r, input logic [N-1:0] q, input bit lk);
        @(negedge clk);
        rst = r; req = q; lock = lk;
        @(posedge clk);
        model_step(r, q, lk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [N-1:0] eg,
                       input logic [EBW-1:0] ei, input bit ev, input bit ep);
        vectors++;
        if ({gnt, gnt_idx, gnt_valid, preempt} !== {eg, ei, ev, ep}) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b preempt=%b, want gnt=%b idx=%0d valid=%b preempt=%b",
                     name, gnt, gnt_idx, gnt_valid, preempt, eg, ei, ev, ep);
        end else begin
            $display("ok   %s: req=%b lock=%b rst=%b gnt=%b idx=%0d preempt=%b",
                     name, req, lock, rst, gnt, gnt_idx, preempt);
        end
    endtask

    task automatic check_model(input string name);
        logic [N-1:0]   eg;
        logic [EBW-1:0] ei;
        eg = '0;
        ei = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ei = EBW'(m_owner);
        end
        cmp(name, eg, ei, m_owner >= 0, m_pre);
    endtask

    typedef struct {
        bit             rst;
        logic [N-1:0]   req;
        bit             lock;
        logic [N-1:0]   gnt;
        logic [EBW-1:0] idx;
        bit             pre;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit r, input logic [N-1:0] q, input bit lk,
                       input logic [N-1:0] g, input logic [EBW-1:0] i, input bit p);
        vec_t v;
        v.rst = r; v.req = q; v.lock = lk; v.gnt = g; v.idx = i; v.pre = p;
        tv.push_back(v);
    endtask

    initial begin
        logic [N-1:0] rnd_req;
        logic [N-1:0] eg;
        logic [N-1:0] flip;
        int           cur;
        int           nxt;

        rst = 1'b1; req = '0; lock = 1'b0;

        // Idle after reset, then grant / release hand-over
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b1010, 0, 4'b0010, 1, 0);
        add(0, 4'b1010, 0, 4'b0010, 1, 0);
        add(0, 4'b1010, 0, 4'b0010, 1, 0);
        add(0, 4'b1000, 0, 4'b1000, 3, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);
        // Timeout preemption
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 0, 0);
        add(0, 4'b0101, 0, 4'b0001, 0, 0);
        add(0, 4'b0101, 0, 4'b0001, 0, 0);
        add(0, 4'b0101, 0, 4'b0001, 0, 0);
        add(0, 4'b0101, 0, 4'b0100, 2, 1);
        add(0, 4'b0101, 0, 4'b0100, 2, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);
        // Same with LOCK held past the limit, then dropped
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b0001, 1, 4'b0001, 0, 0);
        add(0, 4'b0101, 1, 4'b0001, 0, 0);
        add(0, 4'b0101, 1, 4'b0001, 0, 0);
        add(0, 4'b0101, 1, 4'b0001, 0, 0);
        add(0, 4'b0101, 1, 4'b0001, 0, 0);
        add(0, 4'b0101, 1, 4'b0001, 0, 0);
        add(0, 4'b0101, 0, 4'b0100, 2, 1);
        add(0, 4'b0101, 0, 4'b0100, 2, 0);
        // Reset mid-grant, then pointer restarts at 0
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b1000, 0, 4'b1000, 3, 0);
        add(0, 4'b1111, 0, 4'b1000, 3, 0);
        add(1, 4'b1111, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].req, tv[i].lock);
            cmp($sformatf("table[%0d]", i), tv[i].gnt, tv[i].idx, |tv[i].gnt, tv[i].pre);
        end

        // Fairness: release after two cycles and re-request; order 0,1,2,3,0
        drive(1, 4'b0000, 0);
        drive(0, 4'b1111, 0);
        cmp("fair_first", 4'b0001, 0, 1, 0);
        for (int g = 1; g <= 4; g++) begin
            cur = (g - 1) % N;
            nxt = g % N;
            drive(0, 4'b1111, 0);
            check_model("fair_hold");
            rnd_req = 4'b1111;
            rnd_req[cur] = 1'b0;
            drive(0, rnd_req, 0);
            eg = '0;
            eg[nxt] = 1'b1;
            cmp($sformatf("fair_grant%0d", g), eg, EBW'(nxt), 1, 0);
        end

        // Lone owner held long enough to saturate the hold counter
        drive(1, 4'b0000, 0);
        for (int i = 0; i < 300; i++) begin
            drive(0, 4'b0100, 0);
            cmp("lone_owner", 4'b0100, 2, 1, 0);
        end
        drive(0, 4'b0101, 0);
        cmp("lone_late_preempt", 4'b0001, 0, 1, 1);

        // Randomized traffic against the model
        drive(1, 4'b0000, 0);
        rnd_req = '0;
        for (int i = 0; i < 2000; i++) begin
            flip = '0;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 3) == 0);
            rnd_req = rnd_req ^ flip;
            drive($urandom_range(0, 99) == 0, rnd_req, $urandom_range(0, 9) < 2);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gppcu_rr_arbiter.md
Name: gppcu_rr_arbiter

Overview:
Round-robin arbiter that shares one GPPCU datapath resource among 2^EBW requesters. It selects the winner with a rotated priority-encode of the request vector and holds the grant while the owner keeps requesting. After HOLD_MAX cycles it revokes the grant if another requester is waiting. It sits between the requesting lanes and the shared resource's operand mux, which it drives through GNT_IDX.

Parameters:
EBW, 4, encoder bitwidth; number of requesters N = 1<<EBW.
HOLD_MAX, 8, maximum grant cycles before forced rotation; 0 = unlimited (no preemption); range 0..255.
CNTW, 8, hold-counter width; must satisfy HOLD_MAX < 2^CNTW.

Ports:
CLK  input  1  single clock, all state updates on rising edge.
RST  input  1  synchronous reset, active-high.
REQ  input  N  per-requester request level; held high until done.
LOCK  input  1  owner-asserted; suppresses timeout preemption while high.
GNT  output  N  one-hot grant, registered; all-zero when idle.
GNT_IDX  output  EBW  binary index of owner, registered; 0 when idle.
GNT_VALID  output  1  high when GNT is non-zero.
PREEMPT  output  1  one-cycle pulse on the edge a grant is revoked by timeout.

Behaviour:
- Reset (RST=1 at an edge): GNT=0, GNT_IDX=0, GNT_VALID=0, PREEMPT=0, ptr=0, hold counter=0, state=IDLE. RST takes precedence over every other input. Reset mid-grant drops GNT on that edge with no PREEMPT pulse.
- State machine: states IDLE and OWNED.
- ptr (EBW bits) marks the highest-priority index. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, wrapping mod N.
- Winner = first set bit of REQ in search order, computed combinationally from the REQ value sampled at the edge.
- IDLE: if REQ != 0 at an edge, go to OWNED, GNT=onehot(winner), GNT_IDX=winner, count=1. Otherwise stay IDLE. Latency from REQ rise to GNT is 1 cycle.
- OWNED, owner's REQ bit = 0 at an edge (release):
  - ptr <= owner+1 (wraps).
  - Re-arbitrate on the same edge over REQ with the owner's bit ignored, using search start owner+1.
  - If there is a winner, grant it with count=1; hand-over has zero dead cycles. If not, go to IDLE.
- OWNED, owner still requesting, timeout condition met (HOLD_MAX!=0 and count>=HOLD_MAX and LOCK=0 and another REQ bit set):
  - Revoke: ptr <= owner+1.
  - Grant the next waiting requester (search from owner+1, owner excluded), count=1, PREEMPT=1 for that one cycle.
- OWNED, otherwise: hold GNT. count increments and saturates at 2^CNTW-1.
- No other requester pending at timeout: keep the grant, no PREEMPT, count saturates. Preemption happens on the first edge where another request appears while count>=HOLD_MAX.
- LOCK deasserted after the limit was exceeded: preemption may occur on the next edge if others are pending.
- Invariants: GNT is always zero or one-hot; GNT_VALID = |GNT; GNT_IDX matches GNT. Outputs are registered with no combinational path from REQ.
- A preempted requester that keeps REQ high re-enters arbitration at the lowest rotated priority.
- N=2 (EBW=1) must work; ptr wrap from N-1 goes to 0.

Test Plan:
Bench uses EBW=2 (N=4), HOLD_MAX=4.
1. Reset then REQ=4'b0000 for 5 cycles -> GNT=0, GNT_VALID=0, GNT_IDX=0, PREEMPT=0 throughout.
2. From reset, REQ=4'b1010 at edge t -> GNT=4'b0010, GNT_IDX=1 at t+1. REQ[1] drops at edge t+3 -> GNT=4'b1000, GNT_IDX=3 at t+4, no idle cycle.
3. Fairness: REQ=4'b1111, each owner releases after 2 cycles then re-requests -> grant order 0,1,2,3,0; no index is granted twice before all four are served.
4. Timeout: REQ=4'b0001 held, REQ[2] raised on cycle 2 of the grant -> after 4 grant cycles GNT moves 4'b0001→4'b0100 with a single-cycle PREEMPT=1. Same test with LOCK=1 -> GNT stays 4'b0001, PREEMPT=0 until LOCK drops, then preempts on the next edge.
5. Lone owner: REQ=4'b0100 held 300 cycles -> GNT=4'b0100 constant, PREEMPT never pulses, no counter wrap.
6. RST=1 pulsed while GNT=4'b1000 and REQ=4'b1111 -> all outputs 0 at that edge. On the first edge after reset releases, GNT=4'b0001 (ptr reset to 0).
